bus_request_agent: RTL and testbench

- Device-side client of the FIFO-ordered bus arbiter.
- Drives one bit of the arbiter's request flag vector and waits until the arbiter's grant output carries this device's ID.
- Then owns the bus for a latched number of word transfers, each completed by a target Ack handshake.
- Finally withdraws its request and waits until the arbiter has moved the grant away. One instance per bus master.

---
 rtl/bus_request_agent_if.sv | 27 ++
 rtl/bus_request_agent.sv | 150 +++++++++++++++
 tb/tb_bus_request_agent.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_request_agent_if.sv
// Signal bundle between one bus master's request agent and its environment (arbiter, target, client).
// Latency: none, wires only.
// Backpressure: carried by Ack (target) and Grant (arbiter); the agent side is the master modport.
interface bus_request_agent_if #(
    parameter int LENW = 4
);
    logic            Start;
    logic [LENW-1:0] Len;
    logic [2:0]      Grant;
    logic            Ack;
    logic            ReqFlag;
    logic            BusEn;
    logic [LENW-1:0] WordCnt;
    logic            Busy;
    logic            Done;
    logic            Err;

    modport master (
        input  Start, Len, Grant, Ack,
        output ReqFlag, BusEn, WordCnt, Busy, Done, Err
    );

    modport slave (
        output Start, Len, Grant, Ack,
        input  ReqFlag, BusEn, WordCnt, Busy, Done, Err
    );
endinterface

// File: rtl/bus_request_agent.sv
// Device-side client of the FIFO-ordered bus arbiter: request, wait for Grant==ID, move Len words, release.
// Latency: Start to first BusEn is 3 cycles minimum; all outputs registered except BusEn (state & Grant).
// Backpressure: Ack=0 holds the current word; optional grant-wait timeout under macro GRANT_TIMEOUT_EN.
module bus_request_agent #(
    parameter logic [2:0] ID      = 3'd1,
    parameter int         LENW    = 4,
    parameter int         TIMEOUT = 64
) (
    input  logic                Clk,
    input  logic                Rst,
    bus_request_agent_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAITG = 3'd2,
        S_XFER  = 3'd3,
        S_REL   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_word_cnt;
    logic            r_req_flag;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_granted;
    logic            w_start_ok;
    logic            w_last_word;
    logic            w_timeout;
    logic            w_latch_len;
    logic [LENW-1:0] w_word_cnt_d;
    logic            w_req_flag_d;
    logic            w_busy_d;
    logic            w_done_d;
    logic            w_err_d;

    // ID 0 is the arbiter's "nobody" code and the wait counter needs at least two states.
    generate
        if (ID == 3'd0 || TIMEOUT < 2) begin : g_bad_params
            $error("bus_request_agent: ID must be 1..7 and TIMEOUT at least 2");
        end
    endgenerate

    assign w_granted   = (bus.Grant == ID);
    assign w_start_ok  = bus.Start && (bus.Len != '0);
    // Exit on the Ack of word Len-1 so the counter never has to hold Len+1 or wrap.
    assign w_last_word = bus.Ack && (r_word_cnt == r_len - LENW'(1));

`ifdef GRANT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] r_tmo_cnt;

    // Cycles spent waiting for the grant; held at zero outside WAITG so every wait starts fresh.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAITG) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_WAITG) && (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register; reset drops the tenure wherever it is, which the arbiter sees as a release.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a lost grant in XFER is treated like the end of the tenure.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_REQ;
            S_REQ:   w_next = S_WAITG;
            S_WAITG: begin
                if (w_granted) begin
                    w_next = S_XFER;
                end else if (w_timeout) begin
                    w_next = S_REL;
                end
            end
            S_XFER:  if (!w_granted || w_last_word) w_next = S_REL;
            S_REL:   if (!w_granted) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line up with the state they describe.
    always_comb begin
        w_req_flag_d = (w_next == S_WAITG) || (w_next == S_XFER);
        w_busy_d     = (w_next != S_IDLE);
        w_done_d     = (w_next == S_DONE);
        w_err_d      = w_timeout && !w_granted;
        w_latch_len  = (r_state == S_IDLE) && w_start_ok;
        w_word_cnt_d = r_word_cnt;
        if (w_latch_len) begin
            w_word_cnt_d = '0;
        end else if ((r_state == S_XFER) && w_granted && bus.Ack) begin
            w_word_cnt_d = r_word_cnt + LENW'(1);
        end
    end

    // Output and length registers; WordCnt keeps its final value until the next accepted Start.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_req_flag <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_latch_len) begin
                r_len <= bus.Len;
            end
            r_word_cnt <= w_word_cnt_d;
            r_req_flag <= w_req_flag_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_err      <= w_err_d;
        end
    end

    // BusEn follows Grant combinationally so a grant fault releases the bus in the same cycle.
    assign bus.BusEn   = (r_state == S_XFER) && w_granted;
    assign bus.ReqFlag = r_req_flag;
    assign bus.WordCnt = r_word_cnt;
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.Err     = r_err;

endmodule

// File: tb/tb_bus_request_agent.sv
// Bench for bus_request_agent: directed tenures against a phase-level reference model.
// The model is checked every falling edge; literal checks pin key points of each scenario.
// Timeout scenario is only exercised when GRANT_TIMEOUT_EN is defined.
module tb_bus_request_agent;

    localparam logic [2:0] ID      = 3'd1;
    localparam int         LENW    = 4;
    localparam int         TIMEOUT = 8;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int QW     = 6;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int QW     = 10;
`endif

    logic Clk;
    logic Rst;

    bus_request_agent_if #(.LENW(LENW)) bif ();

    bus_request_agent #(
        .ID      (ID),
        .LENW    (LENW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: where the tenure stands, in terms of what the spec promises.
    typedef enum int {P_OFF, P_ASK, P_QUEUED, P_OWN, P_LEAVE, P_FIN} phase_t;
    phase_t ph;
    int     m_len, m_cnt, m_tmo;
    bit     m_err;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ph = P_OFF; m_len = 0; m_cnt = 0; m_tmo = 0; m_err = 0;
        end else begin
            m_err = 0;
            case (ph)
                P_OFF:    if (bif.Start && bif.Len != 0) begin
                              ph = P_ASK; m_len = int'(bif.Len); m_cnt = 0;
                          end
                P_ASK:    begin ph = P_QUEUED; m_tmo = 0; end
                P_QUEUED: if (bif.Grant == ID) ph = P_OWN;
                          else if (TMO_EN && m_tmo == TIMEOUT - 1) begin ph = P_LEAVE; m_err = 1; end
                          else m_tmo++;
                P_OWN:    if (bif.Grant != ID) ph = P_LEAVE;
                          else if (bif.Ack) begin
                              m_cnt++;
                              if (m_cnt == m_len) ph = P_LEAVE;
                          end
                P_LEAVE:  if (bif.Grant != ID) ph = P_FIN;
                P_FIN:    ph = P_OFF;
                default:  ph = P_OFF;
            endcase
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge Clk) begin
        chk("m_ReqFlag", int'(bif.ReqFlag), int'(ph == P_QUEUED || ph == P_OWN));
        chk("m_BusEn",   int'(bif.BusEn),   int'(ph == P_OWN && bif.Grant == ID));
        chk("m_WordCnt", int'(bif.WordCnt), m_cnt);
        chk("m_Busy",    int'(bif.Busy),    int'(ph != P_OFF));
        chk("m_Done",    int'(bif.Done),    int'(ph == P_FIN));
        chk("m_Err",     int'(bif.Err),     int'(m_err));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_tenure(input int len);
        bif.Start = 1'b1;
        bif.Len   = LENW'(len);
        tick();
        bif.Start = 1'b0;
    endtask

    task automatic release_grant(input string tag);
        bif.Grant = 3'd0;
        tick();
        chk({tag, "_done_pulse"}, int'(bif.Done), 1);
        tick();
        chk({tag, "_done_low"}, int'(bif.Done), 0);
        chk({tag, "_busy_low"}, int'(bif.Busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        Rst = 1'b1;
        bif.Start = 1'b0; bif.Len = '0; bif.Grant = 3'd0; bif.Ack = 1'b0;
        tick(); tick();
        chk("rst_reqflag", int'(bif.ReqFlag), 0);
        chk("rst_busen",   int'(bif.BusEn),   0);
        chk("rst_wordcnt", int'(bif.WordCnt), 0);
        chk("rst_busy",    int'(bif.Busy),    0);
        chk("rst_done",    int'(bif.Done),    0);
        chk("rst_err",     int'(bif.Err),     0);
        Rst = 1'b0;
        tick();

        // Basic tenure, Len=3, grant two cycles after ReqFlag rises, Ack always high.
        start_tenure(3);
        chk("t1_busy_req", int'(bif.Busy), 1);
        chk("t1_reqflag_req", int'(bif.ReqFlag), 0);
        tick();
        chk("t1_reqflag_up", int'(bif.ReqFlag), 1);
        tick(); tick();
        bif.Grant = ID; bif.Ack = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bif.BusEn) en_cnt++;
            if (i < 3) chk("t1_wordcnt_seq", int'(bif.WordCnt), i);
        end
        chk("t1_busen_cycles", en_cnt, 3);
        chk("t1_wordcnt_final", int'(bif.WordCnt), 3);
        chk("t1_reqflag_down", int'(bif.ReqFlag), 0);
        bif.Ack = 1'b0;
        release_grant("t1");

        // Ack stalls 0,1,0,0,1 on a two-word tenure.
        start_tenure(2);
        tick();
        bif.Grant = ID; bif.Ack = 1'b0;
        tick();
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bif.Ack = (i == 1 || i == 4);
            if (bif.BusEn) en_cnt++;
            tick();
        end
        chk("t2_busen_cycles", en_cnt, 5);
        chk("t2_wordcnt", int'(bif.WordCnt), 2);
        chk("t2_busen_off", int'(bif.BusEn), 0);
        bif.Ack = 1'b0;
        release_grant("t2");

        // Queue wait behind device 3, with Start pulses that must be ignored.
        start_tenure(1);
        tick();
        bif.Grant = 3'd3;
        en_cnt = 0;
        for (int i = 0; i < QW; i++) begin
            if (bif.BusEn) en_cnt++;
            bif.Start = i[0];
            bif.Len   = 4'd5;
            tick();
        end
        bif.Start = 1'b0;
        chk("t3_no_busen_wait", en_cnt, 0);
        bif.Grant = ID;
        chk("t3_busen_same_cycle", int'(bif.BusEn), 0);
        tick();
        chk("t3_busen_next", int'(bif.BusEn), 1);
        bif.Ack = 1'b1;
        tick();
        chk("t3_len_kept", int'(bif.WordCnt), 1);
        chk("t3_rel_busen", int'(bif.BusEn), 0);
        bif.Ack = 1'b0;
        release_grant("t3");

        // Len=0 Start is ignored.
        bif.Start = 1'b1; bif.Len = 4'd0;
        tick();
        bif.Start = 1'b0;
        chk("t4_len0_busy", int'(bif.Busy), 0);
        tick();
        chk("t4_len0_req", int'(bif.ReqFlag), 0);
        chk("t4_len0_done", int'(bif.Done), 0);

        // Start during XFER does not change the tenure length.
        start_tenure(2);
        tick();
        bif.Grant = ID;
        tick();
        bif.Start = 1'b1; bif.Len = 4'd7; bif.Ack = 1'b1;
        tick();
        bif.Start = 1'b0;
        tick();
        chk("t4_busy_start_cnt", int'(bif.WordCnt), 2);
        chk("t4_busy_start_rel", int'(bif.BusEn), 0);
        bif.Ack = 1'b0;
        release_grant("t4");

        // Reset mid-XFER after one of four words.
        start_tenure(4);
        tick();
        bif.Grant = ID; bif.Ack = 1'b1;
        tick(); tick();
        chk("t5_pre_cnt", int'(bif.WordCnt), 1);
        bif.Ack = 1'b0;
        Rst = 1'b1;
        #1;
        chk("t5_rst_req",  int'(bif.ReqFlag), 0);
        chk("t5_rst_en",   int'(bif.BusEn),   0);
        chk("t5_rst_cnt",  int'(bif.WordCnt), 0);
        chk("t5_rst_busy", int'(bif.Busy),    0);
        tick();
        Rst = 1'b0; bif.Grant = 3'd0;
        tick();
        start_tenure(1);
        tick();
        bif.Grant = ID; bif.Ack = 1'b1;
        tick();
        chk("t5_after_busen", int'(bif.BusEn), 1);
        tick();
        chk("t5_after_cnt", int'(bif.WordCnt), 1);
        bif.Ack = 1'b0;
        release_grant("t5");

`ifdef GRANT_TIMEOUT_EN
        // Timeout: grant stuck on device 2.
        start_tenure(1);
        bif.Grant = 3'd2;
        tick();
        en_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8 && bif.Err) en_cnt++;
        end
        chk("t6_no_early_err", en_cnt, 0);
        chk("t6_err_pulse", int'(bif.Err), 1);
        chk("t6_req_drop", int'(bif.ReqFlag), 0);
        tick();
        chk("t6_done", int'(bif.Done), 1);
        chk("t6_err_once", int'(bif.Err), 0);
        tick();
        chk("t6_idle", int'(bif.Busy), 0);

        // Grant arrives on the timeout cycle: grant wins.
        start_tenure(1);
        bif.Grant = 3'd2;
        tick();
        for (int k = 1; k <= 7; k++) tick();
        bif.Grant = ID;
        tick();
        chk("t6_grant_wins_err", int'(bif.Err), 0);
        chk("t6_grant_wins_en", int'(bif.BusEn), 1);
        bif.Ack = 1'b1;
        tick();
        bif.Ack = 1'b0;
        release_grant("t6");
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
